// File: rtl/ifu_fetch.sv
// ifu_fetch: PC register, next-PC select and registered IF/ID stage for the MIPS core.
// Optional build macro DELAY_SLOT_EN: when defined, a redirect still captures the delay-slot
// instruction; when undefined, a redirect inserts a bubble into IF/ID.
module ifu_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ima,
    input  logic [31:0] imd,
    output logic [31:0] pc,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        if_adel
);
    localparam logic [32:0] IM_BYTES = 33'd4 << IM_AW;
    logic        adel;
    logic [31:0] cap_instr;
    logic        bubble;
    // Memory offset and address-error detection for the current fetch PC
    always_comb begin
        ima       = pc - IM_BASE;
        adel      = (pc[1:0] != 2'b00) || (pc < IM_BASE) || ({1'b0, ima} >= IM_BYTES);
        cap_instr = adel ? 32'h0 : imd;
`ifdef DELAY_SLOT_EN
        bubble    = 1'b0;
`else
        bubble    = redirect_valid;
`endif
    end
    // PC update and IF/ID capture: reset beats stall, stall beats redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= PC_RESET;
            if_pc    <= 32'h0;
            if_instr <= 32'h0;
            if_valid <= 1'b0;
            if_adel  <= 1'b0;
        end else if (!stall) begin
            pc       <= redirect_valid ? redirect_pc : pc + 32'd4;
            if_pc    <= pc;
            if_instr <= bubble ? 32'h0 : cap_instr;
            if_valid <= !bubble;
            if_adel  <= bubble ? 1'b0 : adel;
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed scoreboard bench for ifu_fetch with a combinational instruction memory.
module tb_ifu_fetch;
`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ima;
        logic [31:0] if_pc;
        logic [31:0] if_instr;
        logic        v;
        logic        a;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid;
    logic [31:0] redirect_pc, ima, imd, pc, if_pc, if_instr;
    logic        if_valid, if_adel;
    logic [31:0] mem [1024];
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;

    ifu_fetch dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .ima(ima), .imd(imd), .pc(pc), .if_pc(if_pc),
        .if_instr(if_instr), .if_valid(if_valid), .if_adel(if_adel)
    );

    always #5 clk = ~clk;
    assign imd = mem[ima[11:2]];

    // Monitor: compare the DUT state after each edge against the oldest expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                exp_t g;
                e = q.pop_front();
                g = '{pc, ima, if_pc, if_instr, if_valid, if_adel};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL step%0d got pc=%h ima=%h if_pc=%h instr=%h v=%b adel=%b required pc=%h ima=%h if_pc=%h instr=%h v=%b adel=%b",
                             checks, g.pc, g.ima, g.if_pc, g.if_instr, g.v, g.a,
                             e.pc, e.ima, e.if_pc, e.if_instr, e.v, e.a);
                end
            end
        end
    end

    task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                        input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                        input logic [31:0] e_instr, input logic e_v, input logic e_a);
        reset          = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        q.push_back('{e_pc, e_pc - 32'h3000, e_ifpc, e_instr, e_v, e_a});
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 16'(i)};
        mem[0] = 32'h1111_1111;
        mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        // reset state
        step(1, 0, 0, 0, 32'h3000, 32'h0, 32'h0, 0, 0);
        // free-running fetch
        step(0, 0, 0, 0, 32'h3004, 32'h3000, 32'h1111_1111, 1, 0);
        step(0, 0, 0, 0, 32'h3008, 32'h3004, 32'h2222_2222, 1, 0);
        // stall two cycles at 0x3008
        step(0, 1, 0, 0, 32'h3008, 32'h3004, 32'h2222_2222, 1, 0);
        step(0, 1, 0, 0, 32'h3008, 32'h3004, 32'h2222_2222, 1, 0);
        step(0, 0, 0, 0, 32'h300C, 32'h3008, 32'h3333_3333, 1, 0);
        step(0, 0, 0, 0, 32'h3010, 32'h300C, 32'hC0DE_0003, 1, 0);
        // redirect from 0x3010 to 0x3100
        step(0, 0, 1, 32'h3100, 32'h3100, 32'h3010, DS ? 32'hC0DE_0004 : 32'h0, DS, 0);
        step(0, 0, 0, 0, 32'h3104, 32'h3100, 32'hC0DE_0040, 1, 0);
        // redirect under stall is ignored, then honoured after release
        step(0, 1, 1, 32'h3200, 32'h3104, 32'h3100, 32'hC0DE_0040, 1, 0);
        step(0, 0, 1, 32'h3200, 32'h3200, 32'h3104, DS ? 32'hC0DE_0041 : 32'h0, DS, 0);
        step(0, 0, 0, 0, 32'h3204, 32'h3200, 32'hC0DE_0080, 1, 0);
        // misaligned target
        step(0, 0, 1, 32'h3102, 32'h3102, 32'h3204, DS ? 32'hC0DE_0081 : 32'h0, DS, 0);
        step(0, 0, 0, 0, 32'h3106, 32'h3102, 32'h0, 1, 1);
        // below IM_BASE
        step(0, 0, 1, 32'h2FFC, 32'h2FFC, 32'h3106, 32'h0, DS, DS);
        step(0, 0, 0, 0, 32'h3000, 32'h2FFC, 32'h0, 1, 1);
        // one past the end of memory
        step(0, 0, 1, 32'h4000, 32'h4000, 32'h3000, DS ? 32'h1111_1111 : 32'h0, DS, 0);
        step(0, 0, 0, 0, 32'h4004, 32'h4000, 32'h0, 1, 1);
        // last legal word
        step(0, 0, 1, 32'h3FFC, 32'h3FFC, 32'h4004, 32'h0, DS, DS);
        step(0, 0, 0, 0, 32'h4000, 32'h3FFC, 32'hC0DE_03FF, 1, 0);
        // reset during a stall at 0x3040
        step(0, 0, 1, 32'h3040, 32'h3040, 32'h4000, 32'h0, DS, DS);
        step(0, 1, 0, 0, 32'h3040, 32'h4000, 32'h0, DS, DS);
        step(1, 1, 1, 32'h3500, 32'h3000, 32'h0, 32'h0, 0, 0);
        step(0, 0, 0, 0, 32'h3004, 32'h3000, 32'h1111_1111, 1, 0);
        reset = 1'b0; stall = 1'b1; redirect_valid = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain got %0d pending required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
